// File: rtl/anc_pkg.sv
// Shared defaults, FSM state type and parameter legality check for the
// anti-noise sample transmitter.
package anc_pkg;

  localparam int unsigned DefSamplePeriod = 2048;
  localparam int unsigned DefDataW        = 16;
  localparam int unsigned DefSyncW        = 4;
  localparam int unsigned DefSclkDiv      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StShift
  } anc_state_e;

  // The whole sync + shift burst plus two spare clocks must fit in one frame.
  function automatic bit params_legal(input int unsigned period, input int unsigned data_w,
                                      input int unsigned sync_w, input int unsigned sclk_div);
    return (period >= 64) && (period <= 65535) &&
           (sync_w >= 1) && (sync_w <= 15) &&
           (sclk_div >= 1) && (sclk_div <= 255) &&
           (data_w >= 1) &&
           (period >= sync_w + data_w * 2 * sclk_div + 2);
  endfunction

endpackage

// File: rtl/anc_sample_serializer.sv
// MSB-first serializer: holds the frame sample, divides the bit clock and
// emits SClk/SData with data changing only while SClk is low.
module anc_sample_serializer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              start_i,
  output logic              sclk_o,
  output logic              sdata_o,
  output logic              done_o
);

  localparam int unsigned PhW  = $clog2(2 * SCLK_DIV);
  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [PhW-1:0]  PhLast  = PhW'(2 * SCLK_DIV - 1);
  localparam logic [PhW-1:0]  PhHigh  = PhW'(SCLK_DIV);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [PhW-1:0]    ph_q, ph_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              active_q, active_d;
  logic              sclk_q, sclk_d;
  logic              sdata_q, sdata_d;
  logic              bit_end;

  assign bit_end = active_q && (ph_q == PhLast);
  assign done_o  = bit_end && (bit_q == BitLast);
  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;

  always_comb begin
    shift_d  = shift_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    active_d = active_q;
    sclk_d   = 1'b0;
    sdata_d  = 1'b0;
    if (load_i) begin
      shift_d  = load_data_i;
      ph_d     = '0;
      bit_d    = '0;
      active_d = 1'b0;
    end else if (start_i) begin
      active_d = 1'b1;
      ph_d     = '0;
      bit_d    = '0;
      sdata_d  = shift_q[DATA_W-1];
      shift_d  = shift_q << 1;
    end else if (done_o) begin
      active_d = 1'b0;
    end else if (bit_end) begin
      // New bit is presented right after the SClk falling edge.
      ph_d    = '0;
      bit_d   = bit_q + 1'b1;
      sdata_d = shift_q[DATA_W-1];
      shift_d = shift_q << 1;
    end else if (active_q) begin
      ph_d    = ph_q + 1'b1;
      sclk_d  = (ph_d >= PhHigh);
      sdata_d = sdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_q  <= '0;
      ph_q     <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      active_q <= active_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
    end
  end

endmodule

// File: rtl/anc_sample_tx.sv
// Anti-noise sample transmitter: one-deep holding register, free-running frame
// counter, frame-sync pulse and serial shift-out of one sample per frame.
module anc_sample_tx
  import anc_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = DefSamplePeriod,
  parameter int unsigned DATA_W        = DefDataW,
  parameter int unsigned SYNC_W        = DefSyncW,
  parameter int unsigned SCLK_DIV      = DefSclkDiv
) (
  input  logic              Clk_100M,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Sample_In,
  input  logic              Sample_Valid,
  output logic              Sample_Ready,
  output logic              SSPIF_Out,
  output logic              SClk_Out,
  output logic              SData_Out,
  output logic              Underrun
);

  if (!params_legal(SAMPLE_PERIOD, DATA_W, SYNC_W, SCLK_DIV)) begin : gen_bad_params
    $fatal(1, "anc_sample_tx: illegal parameter set");
  end

  localparam int unsigned CntW = $clog2(SAMPLE_PERIOD);
  localparam logic [CntW-1:0] PeriodLast = CntW'(SAMPLE_PERIOD - 1);
  localparam logic [CntW-1:0] SyncEnd    = CntW'(SYNC_W);

  logic [CntW-1:0]   cnt_q, cnt_d;
  anc_state_e        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic              hold_full_q, hold_full_d;
  logic              ready_q, sspif_q, underrun_q;
  logic              wrap, fire, start, ser_done;
  logic [DATA_W-1:0] load_data;

  assign wrap      = (cnt_q == PeriodLast);
  assign cnt_d     = wrap ? '0 : cnt_q + 1'b1;
  assign fire      = Sample_Valid && ready_q;
  assign load_data = hold_full_q ? hold_q : last_q;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    if (wrap && hold_full_q) begin
      hold_full_d = 1'b0;
      last_d      = hold_q;
    end
    // A handshake on the wrap edge is only possible with the register empty,
    // so it always fills the register for the following frame.
    if (fire) begin
      hold_full_d = 1'b1;
      hold_d      = Sample_In;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      StIdle: if (wrap) state_d = StSync;
      StSync: begin
        if (cnt_d == SyncEnd) begin
          state_d = StShift;
          start   = 1'b1;
        end
      end
      StShift: if (ser_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      cnt_q       <= PeriodLast;
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      ready_q     <= 1'b0;
      sspif_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      ready_q     <= ~hold_full_d;
      sspif_q     <= (cnt_d < SyncEnd);
      underrun_q  <= wrap && !hold_full_q;
    end
  end

  anc_sample_serializer #(
    .DATA_W   (DATA_W),
    .SCLK_DIV (SCLK_DIV)
  ) u_serializer (
    .clk_i       (Clk_100M),
    .reset_i     (Reset),
    .load_i      (wrap),
    .load_data_i (load_data),
    .start_i     (start),
    .sclk_o      (SClk_Out),
    .sdata_o     (SData_Out),
    .done_o      (ser_done)
  );

  assign Sample_Ready = ready_q;
  assign SSPIF_Out    = sspif_q;
  assign Underrun     = underrun_q;

endmodule

// File: tb/tb_anc_sample_tx.sv
// Self-checking bench for anc_sample_tx: a queue-based frame model predicts every
// output cycle by cycle, plus directed checks on the words seen on SClk rising edges.
module tb_anc_sample_tx;

  localparam int unsigned Period = 64;
  localparam int unsigned SyncW  = 2;
  localparam int unsigned Div    = 1;
  localparam int unsigned DataW  = 16;
  localparam int unsigned ShiftLen = DataW * 2 * Div;

  logic             clk = 1'b0;
  logic             Reset = 1'b1;
  logic [DataW-1:0] Sample_In = '0;
  logic             Sample_Valid = 1'b0;
  logic             Sample_Ready, SSPIF_Out, SClk_Out, SData_Out, Underrun;

  always #5 clk = ~clk;

  anc_sample_tx #(
    .SAMPLE_PERIOD (Period),
    .DATA_W        (DataW),
    .SYNC_W        (SyncW),
    .SCLK_DIV      (Div)
  ) dut (
    .Clk_100M     (clk),
    .Reset        (Reset),
    .Sample_In    (Sample_In),
    .Sample_Valid (Sample_Valid),
    .Sample_Ready (Sample_Ready),
    .SSPIF_Out    (SSPIF_Out),
    .SClk_Out     (SClk_Out),
    .SData_Out    (SData_Out),
    .Underrun     (Underrun)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: cycle number since reset release, samples waiting, current frame sample.
  int               cyc = 0;
  logic [DataW-1:0] pending[$];
  logic [DataW-1:0] cur = '0;
  bit               und = 1'b0;
  bit               ready_m = 1'b0;

  // Receiver-side capture.
  logic             prev_sclk = 1'b0;
  logic [DataW-1:0] sh = '0;
  int               nbits = 0;
  logic [DataW-1:0] frame_word [0:7];
  int               und_cnt = 0;
  int               sspif_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick(input bit rst, input bit valid, input logic [DataW-1:0] data);
    bit  fire;
    int  pc;
    int  idx;
    int  frame;
    bit  in_shift;
    logic e_sspif, e_sclk, e_sdata;
    Reset = rst;
    Sample_Valid = valid;
    Sample_In = data;
    if (rst) begin
      pending.delete();
      cur = '0;
      cyc = 0;
      und = 1'b0;
      ready_m = 1'b0;
    end else begin
      fire = valid && ready_m;
      cyc++;
      und = 1'b0;
      if (((cyc - 1) % Period) == 0) begin
        if (pending.size() > 0) cur = pending.pop_front();
        else und = 1'b1;
      end
      if (fire) pending.push_back(data);
      ready_m = (pending.size() == 0);
    end
    @(posedge clk);
    #1;
    if (cyc == 0) begin
      check("rst_ready", 32'(Sample_Ready), 32'd0);
      check("rst_sspif", 32'(SSPIF_Out), 32'd0);
      check("rst_sclk", 32'(SClk_Out), 32'd0);
      check("rst_sdata", 32'(SData_Out), 32'd0);
      check("rst_underrun", 32'(Underrun), 32'd0);
      nbits = 0;
    end else begin
      pc = (cyc - 1) % Period;
      e_sspif = (pc < SyncW);
      in_shift = (pc >= SyncW) && (pc < SyncW + ShiftLen);
      e_sclk = in_shift && (((pc - SyncW) % (2 * Div)) >= Div);
      idx = DataW - 1 - (pc - SyncW) / (2 * Div);
      e_sdata = in_shift ? cur[idx] : 1'b0;
      check("ready", 32'(Sample_Ready), 32'(ready_m));
      check("sspif", 32'(SSPIF_Out), 32'(e_sspif));
      check("sclk", 32'(SClk_Out), 32'(e_sclk));
      check("sdata", 32'(SData_Out), 32'(e_sdata));
      check("underrun", 32'(Underrun), 32'(und));
      if (pc == 0) nbits = 0;
      frame = (cyc - 1) / Period;
      if (!prev_sclk && SClk_Out) begin
        sh = {sh[DataW-2:0], SData_Out};
        nbits++;
        if (nbits == DataW && frame < 8) frame_word[frame] = sh;
      end
      und_cnt += int'(Underrun);
      sspif_cnt += int'(SSPIF_Out);
    end
    prev_sclk = SClk_Out;
  endtask

  task automatic clear_capture();
    for (int i = 0; i < 8; i++) frame_word[i] = 'x;
    und_cnt = 0;
    sspif_cnt = 0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, '0);
    clear_capture();
  endtask

  task automatic run_until(input int target);
    int guard = 0;
    while (cyc < target && guard < 10000) begin
      tick(1'b0, 1'b0, '0);
      guard++;
    end
  endtask

  initial begin
    // Reset state, then idle frames: sync at 1-2/65-66/129-130, underrun at 1/65/129.
    do_reset(3);
    run_until(130);
    check("idle_underrun_count", 32'(und_cnt), 32'd3);
    check("idle_sspif_count", 32'(sspif_cnt), 32'd6);

    // One sample in frame 1 is shifted in frame 2 and repeated in frame 3.
    do_reset(2);
    run_until(10);
    tick(1'b0, 1'b1, 16'hA5C3);
    run_until(192);
    check("a5c3_frame1", 32'(frame_word[0]), 32'h0000);
    check("a5c3_frame2", 32'(frame_word[1]), 32'hA5C3);
    check("a5c3_frame3_repeat", 32'(frame_word[2]), 32'hA5C3);
    check("a5c3_underrun_count", 32'(und_cnt), 32'd2);

    // Valid held: second sample waits for the frame-2 start.
    do_reset(2);
    run_until(5);
    tick(1'b0, 1'b1, 16'h1111);
    while (cyc < 80) tick(1'b0, 1'b1, 16'h2222);
    run_until(192);
    check("held_frame2", 32'(frame_word[1]), 32'h1111);
    check("held_frame3", 32'(frame_word[2]), 32'h2222);

    // Handshake on the wrap edge: current frame repeats, next carries the sample.
    do_reset(2);
    run_until(64);
    tick(1'b0, 1'b1, 16'h5A5A);
    run_until(192);
    check("wrap_hs_frame2", 32'(frame_word[1]), 32'h0000);
    check("wrap_hs_frame3", 32'(frame_word[2]), 32'h5A5A);
    check("wrap_hs_underrun_count", 32'(und_cnt), 32'd2);

    // Reset during bit 7 of frame 2 aborts the shift at once.
    do_reset(2);
    run_until(10);
    tick(1'b0, 1'b1, 16'hBEEF);
    run_until(81);
    tick(1'b1, 1'b0, '0);
    check("abort_sclk", 32'(SClk_Out), 32'd0);
    check("abort_sdata", 32'(SData_Out), 32'd0);
    tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    check("abort_first_sspif", 32'(SSPIF_Out), 32'd1);
    clear_capture();

    // Random traffic against the model.
    do_reset(2);
    for (int i = 0; i < 640; i++) begin
      tick(1'b0, ($urandom_range(0, 3) == 0), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anc_sample_tx.md
ANC_SAMPLE_TX -- requirements
Module: anc_sample_tx

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 2048: clocks per sample frame (48.83 kHz at 100 MHz); legal range 64..65535.
REQ-002 Parameter DATA_W, default 16: sample width in bits.
REQ-003 Parameter SYNC_W, default 4: SSPIF_Out high width in clocks; legal range 1..15.
REQ-004 Parameter SCLK_DIV, default 4: clocks per SClk half-period; legal range 1..255.
REQ-005 Clk_100M  in  1  single system clock; all logic on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Sample_In  in  DATA_W  two's-complement anti-noise sample.
REQ-008 Sample_Valid  in  1  Sample_In valid.
REQ-009 Sample_Ready  out  1  holding register empty, sample accepted.
REQ-010 SSPIF_Out  out  1  sample-start frame-sync pulse to the downstream receiver.
REQ-011 SClk_Out  out  1  serial bit clock.
REQ-012 SData_Out  out  1  serial data, MSB first.
REQ-013 Underrun  out  1  one-cycle pulse: frame started with no new sample.

Function
REQ-014 PeriodCnt counts 0..SAMPLE_PERIOD-1 and wraps to 0; it is free-running whenever Reset is low.
REQ-015 SSPIF_Out is registered; it is high exactly in cycles where PeriodCnt is 0..SYNC_W-1.
REQ-016 Handshake: transfer occurs on an edge where Sample_Valid and Sample_Ready are both 1; Sample_Ready is registered and equals NOT HoldFull.
REQ-017 While HoldFull is set, Sample_Ready is 0 and Sample_In is ignored; no overwrite occurs.
REQ-018 On the edge that sets PeriodCnt to 0, a full holding register moves to ShiftReg and HoldFull clears (Sample_Ready is 1 the next cycle).
REQ-019 If the holding register is empty at that edge, ShiftReg reloads the previous frame's sample (0 after reset) and Underrun pulses for 1 cycle.
REQ-020 A handshake on the same edge as the frame start fills the holding register for the next frame; the current frame follows REQ-019.
REQ-021 FSM states: IDLE -> SYNC on wrap to 0; SYNC -> SHIFT when PeriodCnt reaches SYNC_W; SHIFT -> IDLE after DATA_W bits.
REQ-022 In SHIFT, each bit lasts 2*SCLK_DIV clocks: SClk_Out is low for SCLK_DIV clocks, then high for SCLK_DIV clocks.
REQ-023 SData_Out changes only with SClk_Out low, at the start of each bit (after the falling edge), so the receiver samples on the SClk rising edge.
REQ-024 In IDLE and SYNC, SClk_Out and SData_Out are 0.
REQ-025 Legal parameters satisfy SAMPLE_PERIOD >= SYNC_W + DATA_W*2*SCLK_DIV + 2; an illegal set is a fatal elaboration error.

Reset
REQ-026 While Reset is high, the block drives: PeriodCnt = SAMPLE_PERIOD-1, FSM = IDLE, HoldFull = 0, ShiftReg = 0, last sample = 0.
REQ-027 While Reset is high, the block drives: Sample_Ready = 0, SSPIF_Out = 0, SClk_Out = 0, SData_Out = 0, Underrun = 0.
REQ-028 The first edge with Reset low wraps PeriodCnt to 0 and raises SSPIF_Out; Sample_Ready goes to 1 on that same edge.
REQ-029 Reset asserted mid-frame aborts the shift immediately; no partial bits are emitted after Reset is sampled.

Structure
REQ-030 Shared package anc_pkg holds the DATA_W default, the timing defaults, and the FSM state enum (IDLE, SYNC, SHIFT).
REQ-031 One sub-module, anc_sample_serializer, contains the ShiftReg, bit counter and SClk divider; its inputs are load/start and its outputs are SClk/SData/done.

Verification (SAMPLE_PERIOD=64, SYNC_W=2, SCLK_DIV=1)
REQ-032 Scenario: release Reset -> SSPIF_Out high for cycles 1-2, then high again at cycles 65-66 and 129-130; Underrun pulses at cycles 1, 65 and 129 if no samples are given.
REQ-033 Scenario: Sample_In=0xA5C3 accepted before cycle 64 -> frame 2 shifts 1010_0101_1100_0011, sampled on the 16 SClk rising edges; SClk is idle after 32 clocks.
REQ-034 Scenario: Sample_Valid held high with 0x1111 then 0x2222 -> 0x2222 is not accepted until frame 2 starts; Sample_Ready is 0 in between.
REQ-035 Scenario: no sample for frame 3 -> frame 3 repeats the frame-2 data and Underrun pulses once.
REQ-036 Scenario: handshake on the same edge as the wrap -> the current frame repeats the previous sample with Underrun=1; the next frame carries the new sample.
REQ-037 Scenario: Reset pulsed during bit 7 -> SClk_Out and SData_Out are 0 the following cycle; the first SSPIF_Out is one cycle after release.
